// File: rtl/gic_pkg.sv
// Link nibble codes, frame lengths and FSM states shared by gic_master and gic_slave.
// Constants only: no latency or flow control of its own.
package gic_pkg;

  localparam logic [3:0] GIC_IDLE = 4'h0;
  localparam logic [3:0] GIC_WR   = 4'hA;
  localparam logic [3:0] GIC_RD   = 4'h5;
  localparam logic [3:0] GIC_ACK  = 4'hC;
  localparam logic [3:0] GIC_ERR  = 4'hE;

  localparam logic [4:0] GIC_WR_LEN = 5'd18;
  localparam logic [4:0] GIC_RD_LEN = 5'd10;

  typedef enum logic [2:0] {
    S_RESET_GAP,
    S_IDLE,
    S_TX,
    S_WAIT,
    S_RX,
    S_DONE_ACK,
    S_DONE_ERR
  } gic_state_e;

endpackage

// File: rtl/gic_nibble_shift.sv
// 32-bit parallel-load / serial-nibble shift register, MSB nibble first; load wins over shift.
// Updates one cycle after load/shift; no backpressure.
module gic_nibble_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  input  logic        shift,
  input  logic [3:0]  shift_in,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[27:0], shift_in};
    end
  end

endmodule

// File: rtl/gic_master.sv
// Wishbone classic slave to 4-bit GIC link bridge, one transaction in flight; GIC_MASTER_TIMEOUT_EN adds a response timeout.
// Header nibble 1 cycle after cyc&stb in IDLE; new requests are not sampled until the previous one has terminated.
module gic_master
  import gic_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1024,
  parameter int unsigned IDLE_GAP = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic [3:0]  gic_dat_o,
  input  logic [3:0]  gic_dat_i
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  gic_state_e       state, state_nxt;
  logic [4:0]       cnt, cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_nxt;
  logic             we_q;
  logic [3:0]       sel_q;
  logic [31:0]      dat_q;
  logic             live, live_nxt;
  logic [3:0]       rx_q;
  logic [3:0]       gic_nxt;
  logic             accept, take;
  logic             tx_load, tx_shift, rx_shift;
  logic [31:0]      tx_load_val, tx_q;
  logic             ack_nxt, err_nxt;
  logic             unused_in;

`ifdef GIC_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;

  // A late reply to a timed-out request must drain before a new frame starts.
  assign accept = wb_cyc_i & wb_stb_i & (rx_q == GIC_IDLE);
`else
  assign accept = wb_cyc_i & wb_stb_i;
`endif

  assign take      = (state == S_IDLE) & accept;
  assign wb_rty_o  = 1'b0;
  assign unused_in = ^{wb_cti_i, wb_bte_i, tx_q[27:0], TIMEOUT[0]};

  gic_nibble_shift u_tx_shift (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (tx_load),
    .load_val (tx_load_val),
    .shift    (tx_shift),
    .shift_in (GIC_IDLE),
    .q        (tx_q)
  );

  gic_nibble_shift u_rx_shift (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (1'b0),
    .load_val (32'h0),
    .shift    (rx_shift),
    .shift_in (rx_q),
    .q        (wb_dat_o)
  );

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gap_nxt     = gap_cnt;
    gic_nxt     = GIC_IDLE;
    tx_load     = 1'b0;
    tx_load_val = wb_adr_i;
    tx_shift    = 1'b0;
    rx_shift    = 1'b0;
    live_nxt    = live & wb_cyc_i;
`ifdef GIC_MASTER_TIMEOUT_EN
    tmo_nxt     = tmo_cnt;
`endif
    case (state)
      S_RESET_GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = S_IDLE;
        else                     gap_nxt   = gap_cnt + GAP_W'(1);
      end
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_TX;
          gic_nxt   = wb_we_i ? GIC_WR : GIC_RD;
          tx_load   = 1'b1;
          cnt_nxt   = 5'd0;
          live_nxt  = 1'b1;
        end
      end
      S_TX: begin
        // cnt is the index of the nibble currently on the line.
        if (cnt == (we_q ? GIC_WR_LEN : GIC_RD_LEN) - 5'd1) begin
          state_nxt = S_WAIT;
`ifdef GIC_MASTER_TIMEOUT_EN
          tmo_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd8) begin
            gic_nxt     = sel_q;
            tx_load     = 1'b1;
            tx_load_val = dat_q;
          end else begin
            gic_nxt  = tx_q[31:28];
            tx_shift = 1'b1;
          end
        end
      end
      S_WAIT: begin
        case (rx_q)
          GIC_IDLE: begin
`ifdef GIC_MASTER_TIMEOUT_EN
            if (tmo_cnt == TMO_LAST) state_nxt = S_DONE_ERR;
            else                     tmo_nxt   = tmo_cnt + TMO_W'(1);
`endif
          end
          GIC_ACK: begin
            if (we_q) begin
              state_nxt = S_DONE_ACK;
            end else begin
              state_nxt = S_RX;
              cnt_nxt   = 5'd0;
            end
          end
          GIC_ERR: state_nxt = S_DONE_ERR;
          default: state_nxt = S_DONE_ERR;
        endcase
      end
      S_RX: begin
        rx_shift = 1'b1;
        if (cnt == 5'd7) state_nxt = S_DONE_ACK;
        else             cnt_nxt   = cnt + 5'd1;
      end
      S_DONE_ACK, S_DONE_ERR: state_nxt = S_IDLE;
      default:                state_nxt = S_RESET_GAP;
    endcase
    // An abandoned cycle still runs the link to completion, silently.
    ack_nxt = (state_nxt == S_DONE_ACK) & live_nxt;
    err_nxt = (state_nxt == S_DONE_ERR) & live_nxt;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_RESET_GAP;
      cnt       <= '0;
      gap_cnt   <= '0;
      we_q      <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      live      <= 1'b0;
      rx_q      <= GIC_IDLE;
      gic_dat_o <= GIC_IDLE;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      gap_cnt   <= gap_nxt;
      live      <= live_nxt;
      rx_q      <= gic_dat_i;
      gic_dat_o <= gic_nxt;
      wb_ack_o  <= ack_nxt;
      wb_err_o  <= err_nxt;
      if (take) begin
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
    end
  end

`ifdef GIC_MASTER_TIMEOUT_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) tmo_cnt <= '0;
    else          tmo_cnt <= tmo_nxt;
  end
`endif

endmodule

// File: tb/tb_gic_master.sv
// Bench for gic_master: Wishbone requests against a scripted link peer, with frame and termination scoreboards.
// Defining GIC_MASTER_TIMEOUT_EN also builds the DUT with TIMEOUT=32 and runs the timeout scenario.
`timescale 1ns/1ps
module tb_gic_master;
  import gic_pkg::*;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } term_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, wdat, rdat;
  logic [3:0]  sel;
  logic        we, cyc, stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack, err, rty;
  logic [3:0]  gic_o, gic_i;

  logic [3:0] exp_nib[$];
  term_t      exp_term[$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gic_master #(.TIMEOUT(32), .IDLE_GAP(16)) dut (
    .wb_clk_i (clk),   .wb_rst_i (rst),
    .wb_adr_i (adr),   .wb_dat_i (wdat),  .wb_sel_i (sel),
    .wb_we_i  (we),    .wb_cyc_i (cyc),   .wb_stb_i (stb),
    .wb_cti_i (cti),   .wb_bte_i (bte),
    .wb_dat_o (rdat),  .wb_ack_o (ack),   .wb_err_o (err),  .wb_rty_o (rty),
    .gic_dat_o(gic_o), .gic_dat_i(gic_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame and termination scoreboard, sampled on the falling edge.
  task automatic monitor();
    logic [3:0] en;
    term_t      et;
    int         left;
    left = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        left = 0;
      end else begin
        if (left > 0 || gic_o !== GIC_IDLE) begin
          n_tests++;
          if (exp_nib.size() == 0) begin
            n_fail++;
            $display("FAIL tx_nibble: got %h, expected no frame", gic_o);
          end else begin
            en = exp_nib.pop_front();
            if (gic_o !== en) begin
              n_fail++;
              $display("FAIL tx_nibble: got %h, expected %h", gic_o, en);
            end
            if (left > 0)          left--;
            else if (en == GIC_WR) left = 17;
            else                   left = 9;
          end
        end
        if (ack || err) begin
          n_tests++;
          if (exp_term.size() == 0) begin
            n_fail++;
            $display("FAIL term_unexpected: got ack=%b err=%b, expected none", ack, err);
          end else begin
            et = exp_term.pop_front();
            if (ack !== !et.is_err || err !== et.is_err) begin
              n_fail++;
              $display("FAIL term_kind: got ack=%b err=%b, expected err=%b", ack, err, et.is_err);
            end else if (et.chk_dat) begin
              n_tests++;
              if (rdat !== et.dat) begin
                n_fail++;
                $display("FAIL rd_data_sb: got %h, expected %h", rdat, et.dat);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic wb_req(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    adr = a; wdat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1;
    exp_nib.push_back(w ? GIC_WR : GIC_RD);
    for (int i = 7; i >= 0; i--) exp_nib.push_back(a[i*4 +: 4]);
    exp_nib.push_back(s);
    if (w) for (int i = 7; i >= 0; i--) exp_nib.push_back(d[i*4 +: 4]);
  endtask

  task automatic wait_tx_done();
    int n;
    n = 0;
    while (exp_nib.size() != 0 && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic drive_resp(input logic [35:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      gic_i = v[35-4*i -: 4];
      tick();
    end
    gic_i = GIC_IDLE;
  endtask

  task automatic wait_term(input int max, output int n);
    n = 0;
    while (!(ack || err) && n < max) begin
      tick();
      n++;
    end
    cyc = 1'b0;
    stb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (gic_o !== 4'h0 || ack !== 1'b0 || err !== 1'b0 || rty !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got gic=%h ack=%b err=%b rty=%b, expected 0 0 0 0", gic_o, ack, err, rty);
    end
    n_tests++;
    if (rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdat: got %h, expected 00000000", rdat);
    end
    rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_write();
    int n;
    wb_req(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
    tick();
    n_tests++;
    if (gic_o !== GIC_WR) begin
      n_fail++;
      $display("FAIL wr_hdr_latency: got %h, expected %h", gic_o, GIC_WR);
    end
    wait_tx_done();
    n_tests++;
    if (exp_nib.size() != 0 || gic_o !== GIC_IDLE) begin
      n_fail++;
      $display("FAIL wr_frame_end: got %0d left, line %h, expected 0 left, line 0", exp_nib.size(), gic_o);
    end
    drive_resp({GIC_ACK, 32'h0}, 1);
    wait_term(10, n);
    n_tests++;
    if (n != 1 || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_ack_latency: got %0d cycles ack=%b, expected 1 cycles ack=1", n, ack);
    end
    tick();
    n_tests++;
    if (ack !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse: got ack=%b err=%b, expected 0 0", ack, err);
    end
  endtask

  task automatic test_read();
    int n;
    wb_req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 32'h1234_5678});
    wait_tx_done();
    drive_resp(36'hC_1234_5678, 9);
    wait_term(10, n);
    n_tests++;
    if (n != 1 || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rd_ack_latency: got %0d cycles ack=%b, expected 1 cycles ack=1", n, ack);
    end
    n_tests++;
    if (rdat !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rd_data: got %h, expected 12345678", rdat);
    end
    tick();
  endtask

  task automatic test_error();
    int n;
    logic [3:0] codes [2];
    codes[0] = GIC_ERR;
    codes[1] = 4'h7;
    for (int k = 0; k < 2; k++) begin
      wb_req(1'b0, 32'h0000_0040 + k, 32'h0, 4'h3);
      exp_term.push_back('{is_err: 1'b1, chk_dat: 1'b0, dat: 32'h0});
      wait_tx_done();
      drive_resp({codes[k], 32'h0}, 1);
      wait_term(10, n);
      n_tests++;
      if (n != 1 || err !== 1'b1 || ack !== 1'b0) begin
        n_fail++;
        $display("FAIL err_code_%h: got %0d cycles err=%b ack=%b, expected 1 1 0", codes[k], n, err, ack);
      end
      tick();
      n_tests++;
      if (err !== 1'b0) begin
        n_fail++;
        $display("FAIL err_pulse_%h: got err=%b, expected 0", codes[k], err);
      end
    end
  endtask

  task automatic test_abandon();
    int hits;
    wb_req(1'b0, 32'h0000_55AA, 32'h0, 4'hF);
    wait_tx_done();
    cyc = 1'b0;
    stb = 1'b0;
    tick();
    drive_resp(36'hC_1234_5678, 9);
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      if (ack || err) hits++;
      tick();
    end
    n_tests++;
    if (hits != 0) begin
      n_fail++;
      $display("FAIL abandon_silent: got %0d terminations, expected 0", hits);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    wb_req(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'h3);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
    wait_tx_done();
    drive_resp({GIC_ACK, 32'h0}, 1);
    wait_term(10, n);
    wb_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 32'hA5A5_0F0F});
    tick();
    n_tests++;
    if (gic_o !== GIC_IDLE) begin
      n_fail++;
      $display("FAIL b2b_gap: got %h, expected 0", gic_o);
    end
    tick();
    n_tests++;
    if (gic_o !== GIC_RD) begin
      n_fail++;
      $display("FAIL b2b_hdr: got %h, expected %h", gic_o, GIC_RD);
    end
    wait_tx_done();
    drive_resp(36'hC_A5A5_0F0F, 9);
    wait_term(10, n);
    n_tests++;
    if (n != 1 || ack !== 1'b1 || rdat !== 32'hA5A5_0F0F) begin
      n_fail++;
      $display("FAIL b2b_read: got %0d cycles ack=%b data=%h, expected 1 1 a5a50f0f", n, ack, rdat);
    end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    int n;
    wb_req(1'b1, 32'h0000_1234, 32'hDEAD_BEEF, 4'hF);
    n = 0;
    while (exp_nib.size() > 13 && n < 30) begin
      tick();
      n++;
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (gic_o !== GIC_IDLE || ack !== 1'b0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got gic=%h ack=%b err=%b, expected 0 0 0", gic_o, ack, err);
    end
    exp_nib.delete();
    wb_req(1'b0, 32'h8000_0000, 32'h0, 4'hF);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 32'h0BAD_CAFE});
    tick();
    tick();
    rst = 1'b0;
    // 16 gap edges, then one edge in IDLE to accept the held request.
    n = 0;
    while (gic_o === GIC_IDLE && n < 40) begin
      tick();
      n++;
    end
    n_tests++;
    if (n != 17 || gic_o !== GIC_RD) begin
      n_fail++;
      $display("FAIL rst_gap: got header %h after %0d edges, expected %h after 17", gic_o, n, GIC_RD);
    end
    wait_tx_done();
    drive_resp(36'hC_0BAD_CAFE, 9);
    wait_term(10, n);
    n_tests++;
    if (n != 1 || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_read_ack: got %0d cycles ack=%b, expected 1 1", n, ack);
    end
    tick();
  endtask

`ifdef GIC_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    wb_req(1'b1, 32'h0000_0044, 32'h1111_2222, 4'hF);
    exp_term.push_back('{is_err: 1'b1, chk_dat: 1'b0, dat: 32'h0});
    wait_tx_done();
    wait_term(60, n);
    n_tests++;
    if (n != 32 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_err: got %0d cycles err=%b, expected 32 1", n, err);
    end
    tick();
    wb_req(1'b0, 32'h0000_0048, 32'h0, 4'hF);
    exp_term.push_back('{is_err: 1'b0, chk_dat: 1'b1, dat: 32'h7654_3210});
    wait_tx_done();
    drive_resp(36'hC_7654_3210, 9);
    wait_term(10, n);
    n_tests++;
    if (n != 1 || ack !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_recover: got %0d cycles ack=%b, expected 1 1", n, ack);
    end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    adr = '0; wdat = '0; sel = '0; we = 1'b0; cyc = 1'b0; stb = 1'b0;
    cti = 3'b111; bte = 2'b01; gic_i = GIC_IDLE;
    fork
      monitor();
    join_none
    test_reset();
    test_write();
    test_read();
    test_error();
    test_abandon();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef GIC_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    repeat (4) tick();
    n_tests++;
    if (exp_nib.size() != 0 || exp_term.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d nibbles %0d terms pending, expected 0 0", exp_nib.size(), exp_term.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
